// File: rtl/swerv_types.sv
// Shared trace types for the SweRV trace path.
// trace_pkt_t : one core cycle of retirement trace, up to TRACE_LANES instructions.
// trace_beat_t: one serialized instruction taken from a single lane of a packet.
// lane_beat() : extracts one lane of a packet as a beat. ecause and tval are
//               forced to 0 unless that lane took an exception or an interrupt.
package swerv_types;

    localparam int unsigned TRACE_LANES = 3;

    typedef struct packed {
        logic [2:0]  trace_rv_i_valid_ip;
        logic [95:0] trace_rv_i_insn_ip;
        logic [95:0] trace_rv_i_address_ip;
        logic [2:0]  trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic [2:0]  trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } trace_pkt_t;

    localparam int unsigned TRACE_PKT_W = $bits(trace_pkt_t);

    typedef struct packed {
        logic [1:0]  slot;
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exception;
        logic        interrupt;
        logic [4:0]  ecause;
        logic [31:0] tval;
    } trace_beat_t;

    // Lane extraction; ecause/tval only carry meaning for trapping lanes.
    function automatic trace_beat_t lane_beat(input trace_pkt_t pkt, input logic [1:0] lane);
        trace_beat_t b;
        b = '0;
        for (int unsigned k = 0; k < TRACE_LANES; k++) begin
            if (lane == 2'(k)) begin
                b.slot      = lane;
                b.insn      = pkt.trace_rv_i_insn_ip[32*k +: 32];
                b.addr      = pkt.trace_rv_i_address_ip[32*k +: 32];
                b.exception = pkt.trace_rv_i_exception_ip[k];
                b.interrupt = pkt.trace_rv_i_interrupt_ip[k];
            end
        end
        if (b.exception || b.interrupt) begin
            b.ecause = pkt.trace_rv_i_ecause_ip;
            b.tval   = pkt.trace_rv_i_tval_ip;
        end
        return b;
    endfunction

endpackage

// File: rtl/swerv_trace_fifo.sv
// Generic synchronous FIFO with flop storage and a direct (unregistered) read of the head entry.
// Ports: clk, rst_l (async active-low), push/din write side, pop/dout read side, full, empty.
// A push while full and a pop while empty are both ignored.
module swerv_trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_d, wr_ptr_q;
    logic [PW-1:0]    rd_ptr_d, rd_ptr_q;
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Equal indices with differing MSBs means the write pointer has lapped the read pointer.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for pointers and storage.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/swerv_trace_unpacker.sv
// Trace unpacker: buffers the core's per-cycle trace packets and serializes their valid
// lanes into a one-instruction-per-beat valid/ready stream.
// Ports: clk, rst_l (async active-low), trace_in (trace_pkt_t, sampled every cycle),
//        out_valid/out_ready handshake, out_slot/out_insn/out_addr/out_exception/
//        out_interrupt/out_ecause/out_tval beat fields, drop_cnt (saturating),
//        overflow (sticky), clr (synchronous clear of drop_cnt and overflow).
// Optional macro RV_TRACE_TIMESTAMP_EN: adds a free-running 32-bit cycle counter,
//        stores its value with each packet and adds the out_tstamp output.
// The head packet stays in the FIFO until its last beat is accepted, so an emitting
// packet occupies one FIFO entry. The beat fields are decoded from the FIFO head and
// a registered mask of lanes already sent; all of them are 0 while the FIFO is empty.
module swerv_trace_unpacker
    import swerv_types::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic [TRACE_PKT_W-1:0] trace_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_slot,
    output logic [31:0]            out_insn,
    output logic [31:0]            out_addr,
    output logic                   out_exception,
    output logic                   out_interrupt,
    output logic [4:0]             out_ecause,
    output logic [31:0]            out_tval,
`ifdef RV_TRACE_TIMESTAMP_EN
    output logic [31:0]            out_tstamp,
`endif
    output logic [CNT_W-1:0]       drop_cnt,
    output logic                   overflow,
    input  logic                   clr
);

    localparam int unsigned PKT_W  = TRACE_PKT_W;
`ifdef RV_TRACE_TIMESTAMP_EN
    localparam int unsigned FIFO_W = PKT_W + 32;
`else
    localparam int unsigned FIFO_W = PKT_W;
`endif

    trace_pkt_t             pkt_in;
    trace_pkt_t             head_pkt;
    trace_beat_t            beat;
    logic                   present;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_W-1:0]      fifo_din, fifo_dout;
    logic [TRACE_LANES-1:0] remaining, lane_oh;
    logic [TRACE_LANES-1:0] done_d, done_q;
    logic [1:0]             lane;
    logic                   accept, last_beat;
    logic [CNT_W-1:0]       drop_cnt_d, drop_cnt_q;
    logic                   overflow_d, overflow_q;

    assign pkt_in  = trace_pkt_t'(trace_in);
    assign present = |pkt_in.trace_rv_i_valid_ip;
    // Full is sampled before any same-cycle pop, so the push side never depends on out_ready.
    assign fifo_push = present && !fifo_full;

`ifdef RV_TRACE_TIMESTAMP_EN
    logic [31:0] tstamp_d, tstamp_q;

    // Free-running cycle counter, stored alongside each packet.
    always_comb begin
        tstamp_d = tstamp_q + 32'(1);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tstamp_q <= '0;
        end else begin
            tstamp_q <= tstamp_d;
        end
    end

    assign fifo_din   = {tstamp_q, trace_in};
    assign out_tstamp = fifo_empty ? '0 : fifo_dout[PKT_W +: 32];
`else
    assign fifo_din = trace_in;
`endif

    swerv_trace_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_l (rst_l),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_pkt = trace_pkt_t'(fifo_dout[PKT_W-1:0]);

    // Serializer: emit the lowest remaining lane; retire the packet on its last beat.
    always_comb begin
        remaining = '0;
        lane      = '0;
        lane_oh   = '0;
        if (!fifo_empty) begin
            remaining = head_pkt.trace_rv_i_valid_ip & ~done_q;
        end
        // Descending scan so the lowest set lane is the last to be written.
        for (int k = TRACE_LANES - 1; k >= 0; k--) begin
            if (remaining[k]) begin
                lane       = 2'(k);
                lane_oh    = '0;
                lane_oh[k] = 1'b1;
            end
        end
        last_beat = ((remaining & ~lane_oh) == '0);
        accept    = !fifo_empty && out_ready;
        fifo_pop  = accept && last_beat;
        done_d    = done_q;
        if (accept) begin
            done_d = last_beat ? '0 : (done_q | lane_oh);
        end
    end

    // Drop accounting; clr wins over a same-cycle drop.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        if (clr) begin
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else if (present && fifo_full) begin
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            done_q     <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q     <= done_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign beat          = fifo_empty ? '0 : lane_beat(head_pkt, lane);
    assign out_valid     = !fifo_empty;
    assign out_slot      = beat.slot;
    assign out_insn      = beat.insn;
    assign out_addr      = beat.addr;
    assign out_exception = beat.exception;
    assign out_interrupt = beat.interrupt;
    assign out_ecause    = beat.ecause;
    assign out_tval      = beat.tval;
    assign drop_cnt      = drop_cnt_q;
    assign overflow      = overflow_q;

endmodule

// File: doc/swerv_trace_unpacker.md
Name: swerv_trace_unpacker

Overview:
Receiving end of the core's per-cycle trace_pkt_t interface, which carries up to 3 retired instructions per cycle.
- Buffers whole packets in a small FIFO.
- Serializes the valid lanes into a one-instruction-per-beat stream with a valid/ready handshake, for a trace sink or debug port.
- The core cannot stall on trace, so packets arriving at a full FIFO are dropped, counted and flagged.

Parameters:
DEPTH, 4, packet FIFO entries (power of 2, at least 2)
CNT_W, 16, width of the saturating drop counter

Ports:
clk  in  1  core clock
rst_l  in  1  async active-low reset
trace_in  in  238 (trace_pkt_t)  trace packet from the core, sampled every cycle
out_valid  out  1  beat valid
out_ready  in  1  sink accepts beat
out_slot  out  2  source lane 0..2
out_insn  out  32  instruction word of the lane
out_addr  out  32  PC of the lane
out_exception  out  1  lane took an exception
out_interrupt  out  1  lane took an interrupt
out_ecause  out  5  cause; 0 unless exception or interrupt
out_tval  out  32  tval; 0 unless exception or interrupt
drop_cnt  out  CNT_W  packets dropped, saturating
overflow  out  1  sticky, set on the first drop
clr  in  1  synchronous clear of drop_cnt and overflow

Behaviour:
Clock and reset:
- One clock (clk). Reset rst_l is asynchronous, active-low.
- Reset values: out_valid=0; every out_* data field=0; drop_cnt=0; overflow=0; FIFO empty; serializer IDLE.

Packet capture:
- A packet is "present" when |trace_rv_i_valid_ip is true; packets with no valid lane are ignored.
- Present and FIFO not full: push.
- Present and FIFO full: drop; drop_cnt+=1, saturating at all-ones; overflow<=1.
- A push in the same cycle as the pop of the last beat of the head packet is allowed. Full is evaluated before the pop, so this case still drops. This keeps full timing free of out_ready.
- clr has priority over an increment in the same cycle.

Serializer states:
- IDLE: FIFO empty, out_valid=0. Go to EMIT when FIFO not empty. The first beat is registered, so a packet pushed in cycle N gives out_valid in cycle N+1.
- EMIT: the head packet is held in a register together with a 3-bit remaining-lane mask (its valid bits).
  - Current lane = lowest set bit of the mask. Lanes are emitted in ascending order 0, 1, 2; invalid lanes are skipped with no bubble.
  - Lane k data: insn[32k+31:32k], addr[32k+31:32k], exception[k], interrupt[k].
  - ecause/tval: driven only when exception[k] or interrupt[k] is set, else 0.
  - On out_valid && out_ready: clear lane k from the mask.
    - Mask becomes zero and FIFO has another packet: load it the next cycle, with no idle gap (back-to-back beats).
    - Mask becomes zero and FIFO is empty: go to IDLE.
- While out_valid && !out_ready, every out_* field stays stable.

Boundary cases:
- Pointers: log2(DEPTH)+1 bits; wrap-around uses the MSB toggle.
- A single-lane packet (e.g. valid=3'b100) produces exactly one beat, with out_slot=2.
- Reset asserted mid-packet: all remaining beats and all FIFO contents are discarded.

Optional Feature:
RV_TRACE_TIMESTAMP_EN:
- Defined:
  - Adds a 32-bit free-running cycle counter (reset 0, wraps).
  - The counter value is stored with each packet at push.
  - Adds output port out_tstamp (32), driven with the stored value on every beat of that packet (0 at reset).
- Undefined: no counter, no port, no extra FIFO width.

Decomposition:
Shared package additions in swerv_types:
- TRACE_LANES=3.
- typedef trace_beat_t: slot[1:0], insn[31:0], addr[31:0], exception, interrupt, ecause[4:0], tval[31:0].

Sub-module: swerv_trace_fifo.
- Generic synchronous FIFO parameterized by WIDTH and DEPTH.
- Ports: push, pop, din, dout, full, empty.
- Async active-low reset.
- The unpacker instantiates it with WIDTH = $bits(trace_pkt_t), plus 32 when RV_TRACE_TIMESTAMP_EN is defined.

Test Plan:
1. Full packet, valid=3'b111, insn={C,B,A}, out_ready held 1 → beats slot 0/1/2 with insn A, B, C on three consecutive cycles, starting the cycle after the push.
2. valid=3'b101, exception=3'b100, ecause=5'd2, tval=0x1234 → two beats. Slot 0 has ecause=0 and tval=0. Slot 2 has exception=1, ecause=2, tval=0x1234.
3. out_ready=0 for 10 cycles, with a 3-lane packet pushed every cycle (DEPTH=4) → after 4 pushes the remaining 6 are dropped; drop_cnt=6, overflow=1. Output stays stable on slot 0 of the first packet.
4. Toggle out_ready randomly over 100 packets with FIFO not overflowing → output beats equal the reference model's lane-ordered stream, with no duplicates or losses.
5. Assert rst_l low while the serializer is in EMIT on lane 1 → out_valid=0 immediately (asynchronously); after release, no beats are emitted until a new packet arrives.
6. RV_TRACE_TIMESTAMP_EN defined; packets pushed at cycles 5 and 9 → every beat of each packet carries out_tstamp 5 and 9 respectively.
